// File: rtl/yoda_pkg.sv
// ---------------------------------------------------------------------------
// yoda_pkg
// Shared geometry constants for the image/mask pipeline, the offset widths
// used by the masker, and the state encoding of the mask motion scheduler.
// No ports (package).
// ---------------------------------------------------------------------------
package yoda_pkg;

   localparam int IMG_ROWS  = 240;
   localparam int IMG_COLS  = 320;
   localparam int MASK_ROWS = 64;
   localparam int MASK_COLS = 64;

   localparam int ROW_W = 8;
   localparam int COL_W = 9;

   // Largest legal top-left offset of the mask on each axis
   localparam int MAX_R = IMG_ROWS - MASK_ROWS;
   localparam int MAX_C = IMG_COLS - MASK_COLS;

   typedef enum logic [1:0] {
      ST_WAIT_FRAME = 2'd0,
      ST_WAIT_BLANK = 2'd1,
      ST_CALC       = 2'd2,
      ST_COMMIT     = 2'd3
   } state_t;

endpackage

// File: rtl/bounce_axis.sv
// ---------------------------------------------------------------------------
// bounce_axis
// Combinational next-position logic for one axis of the bouncing mask.
// Adds or subtracts the step from the current offset and reflects at the
// range limits 0 and MAX, flipping the direction when a limit is reached.
// Ports:
//   offset_i   W   current offset
//   dir_neg_i  1   current direction (0 = increasing, 1 = decreasing)
//   step_i     4   step magnitude
//   offset_o   W   next offset, always within 0..MAX
//   dir_neg_o  1   next direction
// ---------------------------------------------------------------------------
module bounce_axis
   import yoda_pkg::*;
#(
   parameter int W   = ROW_W,
   parameter int MAX = MAX_R
) (
   input  logic [W-1:0] offset_i,
   input  logic         dir_neg_i,
   input  logic [3:0]   step_i,
   output logic [W-1:0] offset_o,
   output logic         dir_neg_o
);

   localparam logic signed [W:0] MAX_S = (W+1)'(MAX);

   // One extra bit so that both overshoot past MAX and undershoot below 0
   // are representable before clamping.
   logic signed [W:0] off_s;
   logic signed [W:0] step_s;
   logic signed [W:0] sum;

   always_comb begin
      off_s     = $signed({1'b0, offset_i});
      step_s    = $signed({{(W-3){1'b0}}, step_i});
      sum       = dir_neg_i ? (off_s - step_s) : (off_s + step_s);
      offset_o  = sum[W-1:0];
      dir_neg_o = dir_neg_i;
      if (!dir_neg_i && (sum >= MAX_S)) begin
         // Landing exactly on MAX also reverses, so the mask never pauses there
         offset_o  = MAX_S[W-1:0];
         dir_neg_o = 1'b1;
      end else if (dir_neg_i && (sum[W] || (sum == '0))) begin
         offset_o  = '0;
         dir_neg_o = 1'b0;
      end
   end

endmodule

// File: rtl/mask_motion_scheduler.sv
// ---------------------------------------------------------------------------
// mask_motion_scheduler
// Drives the masker's row/col offsets so the mask sweeps and bounces across
// the image. A new offset is committed only once a frame transfer has
// completed and the VGA side then enters vertical blanking, so the frame
// buffer is never read with a half-moved mask.
// Ports:
//   clk              1   pixel-domain clock
//   rst              1   synchronous active-high reset
//   enable           1   1 = motion running, 0 = hold offsets
//   frame_done       1   pulse: last pixel of a frame written
//   v_free           1   vertical blanking level (already in clk domain)
//   step_row         4   row step per move
//   step_col         4   col step per move
//   mask_row_offset  8   registered row offset
//   mask_col_offset  9   registered col offset
//   offset_update    1   pulse in the cycle the offsets are (re)loaded
//   frame_count      16  committed-frame counter, wrapping
// ---------------------------------------------------------------------------
module mask_motion_scheduler
   import yoda_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             frame_done,
   input  logic             v_free,
   input  logic [3:0]       step_row,
   input  logic [3:0]       step_col,
   output logic [ROW_W-1:0] mask_row_offset,
   output logic [COL_W-1:0] mask_col_offset,
   output logic             offset_update,
   output logic [15:0]      frame_count
);

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   state_t           state_q;
   logic             v_free_q;
   logic [ROW_W-1:0] row_q, row_hold_q;
   logic [COL_W-1:0] col_q, col_hold_q;
   logic             row_dir_q, row_dir_hold_q;
   logic             col_dir_q, col_dir_hold_q;
   logic             calc_en_q;
   logic [CNT_W-1:0] step_cnt_q;
   logic [15:0]      frame_cnt_q;
   logic             offset_update_q;

   logic [ROW_W-1:0] row_d;
   logic [COL_W-1:0] col_d;
   logic             row_dir_d, col_dir_d;
   logic             move_d;

   bounce_axis #(.W(ROW_W), .MAX(MAX_R)) u_row_axis (
      .offset_i  (row_q),
      .dir_neg_i (row_dir_q),
      .step_i    (step_row),
      .offset_o  (row_d),
      .dir_neg_o (row_dir_d)
   );

   bounce_axis #(.W(COL_W), .MAX(MAX_C)) u_col_axis (
      .offset_i  (col_q),
      .dir_neg_i (col_dir_q),
      .step_i    (step_col),
      .offset_o  (col_d),
      .dir_neg_o (col_dir_d)
   );

   assign move_d = enable && (step_cnt_q == STEP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_WAIT_FRAME;
         v_free_q        <= 1'b0;
         row_q           <= '0;
         col_q           <= '0;
         row_dir_q       <= 1'b0;
         col_dir_q       <= 1'b0;
         row_hold_q      <= '0;
         col_hold_q      <= '0;
         row_dir_hold_q  <= 1'b0;
         col_dir_hold_q  <= 1'b0;
         calc_en_q       <= 1'b0;
         step_cnt_q      <= '0;
         frame_cnt_q     <= '0;
         offset_update_q <= 1'b0;
      end else begin
         // The edge detector runs in every state, so a blanking edge that
         // coincides with frame_done is consumed and not seen in WAIT_BLANK.
         v_free_q        <= v_free;
         offset_update_q <= 1'b0;
         case (state_q)
            ST_WAIT_FRAME: begin
               if (frame_done) state_q <= ST_WAIT_BLANK;
            end
            ST_WAIT_BLANK: begin
               if (v_free && !v_free_q) state_q <= ST_CALC;
            end
            ST_CALC: begin
               // enable is captured here so the commit that follows agrees
               // with the position that was computed.
               calc_en_q <= enable;
               if (move_d) begin
                  row_hold_q     <= row_d;
                  col_hold_q     <= col_d;
                  row_dir_hold_q <= row_dir_d;
                  col_dir_hold_q <= col_dir_d;
               end else begin
                  row_hold_q     <= row_q;
                  col_hold_q     <= col_q;
                  row_dir_hold_q <= row_dir_q;
                  col_dir_hold_q <= col_dir_q;
               end
               state_q <= ST_COMMIT;
            end
            ST_COMMIT: begin
               row_q           <= row_hold_q;
               col_q           <= col_hold_q;
               row_dir_q       <= row_dir_hold_q;
               col_dir_q       <= col_dir_hold_q;
               offset_update_q <= 1'b1;
               frame_cnt_q     <= frame_cnt_q + 16'd1;
               if (calc_en_q) begin
                  step_cnt_q <= (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + CNT_W'(1);
               end
               state_q <= ST_WAIT_FRAME;
            end
            default: state_q <= ST_WAIT_FRAME;
         endcase
      end
   end

   assign mask_row_offset = row_q;
   assign mask_col_offset = col_q;
   assign offset_update   = offset_update_q;
   assign frame_count     = frame_cnt_q;

endmodule
